// File: rtl/crossing_sequencer_pkg.sv
// Shared state encodings, default timing and helpers for the level-crossing sequencer.
package crossing_pkg;

  typedef enum logic [2:0] {OPEN, WARN, LOWER, CLOSED, RAISE, FAULT} master_state_t;
  typedef enum logic [1:0] {T_IDLE, T_IN_WE, T_IN_EW, T_EXIT} track_state_t;

  localparam int unsigned DEF_WARN_CYCLES  = 16;
  localparam int unsigned DEF_MOVE_TIMEOUT = 32;
  localparam int unsigned DEF_CLEAR_HOLD   = 8;
  localparam int unsigned DEF_FLASH_HALF   = 4;
  localparam int unsigned DEF_OCC_TIMEOUT  = 1024;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/crossing_sequencer_if.sv
// Trackside sensors, limit switches and gate/lamp commands for one crossing.
interface crossing_sequencer_if;
  logic enable;
  logic rail_A, rail_B, rail_C, rail_D;
  logic gate_down_ack, gate_up_ack;
  logic gate, gate_dn, gate_up, red_light, bell, fault;

  modport master (
    input  enable, rail_A, rail_B, rail_C, rail_D, gate_down_ack, gate_up_ack,
    output gate, gate_dn, gate_up, red_light, bell, fault
  );

  modport slave (
    output enable, rail_A, rail_B, rail_C, rail_D, gate_down_ack, gate_up_ack,
    input  gate, gate_dn, gate_up, red_light, bell, fault
  );
endinterface

// File: rtl/crossing_sequencer_track_tracker.sv
// One track: sensor synchronisers, edge detect, direction tracking and occupancy timeout.
module track_tracker
  import crossing_pkg::*;
#(
  parameter int unsigned OCC_TIMEOUT = DEF_OCC_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic west,
  input  logic east,
  output logic occupied,
  output logic track_fault
);

  localparam int unsigned OCC_W = $clog2(OCC_TIMEOUT + 1);

  logic [1:0] west_sync, east_sync;
  logic west_prev, east_prev;
  logic west_rise, west_fall, east_rise, east_fall;
  logic exit_east, exit_east_next;
  track_state_t state, state_next;
  logic [OCC_W-1:0] occ_cnt;

  // Synchronise both sensors and register their edge pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      west_sync <= '0;
      east_sync <= '0;
      west_prev <= 1'b0;
      east_prev <= 1'b0;
      west_rise <= 1'b0;
      west_fall <= 1'b0;
      east_rise <= 1'b0;
      east_fall <= 1'b0;
    end else begin
      west_sync <= {west_sync[0], west};
      east_sync <= {east_sync[0], east};
      west_prev <= west_sync[1];
      east_prev <= east_sync[1];
      west_rise <= west_sync[1] & ~west_prev;
      west_fall <= ~west_sync[1] & west_prev;
      east_rise <= east_sync[1] & ~east_prev;
      east_fall <= ~east_sync[1] & east_prev;
    end
  end

  // Tracker state and remembered exit side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= T_IDLE;
      exit_east <= 1'b0;
    end else begin
      state     <= state_next;
      exit_east <= exit_east_next;
    end
  end

  // Next tracker state from sensor edges; the entry-side sensor is ignored once inside.
  always_comb begin
    state_next     = state;
    exit_east_next = exit_east;
    case (state)
      T_IDLE: begin
        if (west_rise) state_next = T_IN_WE;
        else if (east_rise) state_next = T_IN_EW;
      end
      T_IN_WE: begin
        if (east_rise) begin
          state_next     = T_EXIT;
          exit_east_next = 1'b1;
        end
      end
      T_IN_EW: begin
        if (west_rise) begin
          state_next     = T_EXIT;
          exit_east_next = 1'b0;
        end
      end
      T_EXIT: begin
        if (exit_east ? east_fall : west_fall) state_next = T_IDLE;
      end
      default: state_next = T_IDLE;
    endcase
  end

  // Occupancy age: zero while idle, saturates at the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_cnt <= '0;
    else if (state == T_IDLE) occ_cnt <= '0;
    else if (occ_cnt != OCC_W'(OCC_TIMEOUT)) occ_cnt <= occ_cnt + 1'b1;
  end

  assign occupied    = (state != T_IDLE);
  assign track_fault = (occ_cnt == OCC_W'(OCC_TIMEOUT));

endmodule

// File: rtl/crossing_sequencer.sv
// Level-crossing sequencer: two track trackers feeding the gate master FSM.
module crossing_sequencer
  import crossing_pkg::*;
#(
  parameter int unsigned WARN_CYCLES  = DEF_WARN_CYCLES,
  parameter int unsigned MOVE_TIMEOUT = DEF_MOVE_TIMEOUT,
  parameter int unsigned CLEAR_HOLD   = DEF_CLEAR_HOLD,
  parameter int unsigned FLASH_HALF   = DEF_FLASH_HALF,
  parameter int unsigned OCC_TIMEOUT  = DEF_OCC_TIMEOUT
) (
  input logic clk,
  input logic reset,
  crossing_sequencer_if.master bus
);

  localparam int unsigned TIMER_W = $clog2(max3(WARN_CYCLES, MOVE_TIMEOUT, CLEAR_HOLD) + 1);
  localparam int unsigned FLASH_W = $clog2(FLASH_HALF + 1);

  master_state_t state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [FLASH_W-1:0] flash_cnt;
  logic flash_on;
  logic occ0, occ1, tf0, tf1;
  logic any_occ, any_fault, both_acks, expiring;

  track_tracker #(.OCC_TIMEOUT(OCC_TIMEOUT)) u_track0 (
    .clk(clk), .reset(reset), .west(bus.rail_A), .east(bus.rail_B),
    .occupied(occ0), .track_fault(tf0)
  );

  track_tracker #(.OCC_TIMEOUT(OCC_TIMEOUT)) u_track1 (
    .clk(clk), .reset(reset), .west(bus.rail_C), .east(bus.rail_D),
    .occupied(occ1), .track_fault(tf1)
  );

  assign any_occ   = occ0 | occ1;
  assign any_fault = tf0 | tf1;
  assign both_acks = bus.gate_down_ack & bus.gate_up_ack;
  // Timer holds clocks remaining; the transition is taken on the clock it would reach zero.
  assign expiring  = (timer <= TIMER_W'(1));

  // Master state and phase timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= OPEN;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Warning-lamp phase: restarts "on" whenever the crossing is open.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flash_cnt <= '0;
      flash_on  <= 1'b1;
    end else if (state == OPEN) begin
      flash_cnt <= '0;
      flash_on  <= 1'b1;
    end else if (flash_cnt == FLASH_W'(FLASH_HALF - 1)) begin
      flash_cnt <= '0;
      flash_on  <= ~flash_on;
    end else begin
      flash_cnt <= flash_cnt + 1'b1;
    end
  end

  // Next master state; faults override everything, occupancy beats up-ack while raising.
  always_comb begin
    state_next = state;
    timer_next = timer;
    if (any_fault || (both_acks && state != OPEN)) begin
      state_next = FAULT;
      timer_next = '0;
    end else begin
      case (state)
        OPEN: begin
          if (bus.enable && any_occ) begin
            state_next = WARN;
            timer_next = TIMER_W'(WARN_CYCLES);
          end
        end
        WARN: begin
          if (expiring) begin
            state_next = LOWER;
            timer_next = TIMER_W'(MOVE_TIMEOUT);
          end else timer_next = timer - 1'b1;
        end
        LOWER: begin
          if (bus.gate_down_ack) begin
            state_next = CLOSED;
            timer_next = TIMER_W'(CLEAR_HOLD);
          end else if (expiring) begin
            state_next = FAULT;
            timer_next = '0;
          end else timer_next = timer - 1'b1;
        end
        CLOSED: begin
          if (any_occ) timer_next = TIMER_W'(CLEAR_HOLD);
          else if (expiring) begin
            state_next = RAISE;
            timer_next = TIMER_W'(MOVE_TIMEOUT);
          end else timer_next = timer - 1'b1;
        end
        RAISE: begin
          if (any_occ) begin
            state_next = LOWER;
            timer_next = TIMER_W'(MOVE_TIMEOUT);
          end else if (bus.gate_up_ack) begin
            state_next = OPEN;
            timer_next = '0;
          end else if (expiring) begin
            state_next = FAULT;
            timer_next = '0;
          end else timer_next = timer - 1'b1;
        end
        FAULT: ;
        default: state_next = FAULT;
      endcase
    end
  end

  // Gate, lamp and bell outputs decoded from the master state.
  always_comb begin
    bus.gate      = 1'b0;
    bus.gate_dn   = 1'b0;
    bus.gate_up   = 1'b0;
    bus.red_light = 1'b0;
    bus.bell      = 1'b0;
    bus.fault     = 1'b0;
    case (state)
      WARN: begin
        bus.red_light = flash_on;
        bus.bell      = 1'b1;
      end
      LOWER: begin
        bus.gate      = 1'b1;
        bus.gate_dn   = 1'b1;
        bus.red_light = flash_on;
        bus.bell      = 1'b1;
      end
      CLOSED: begin
        bus.gate      = 1'b1;
        bus.red_light = flash_on;
      end
      RAISE: begin
        bus.gate      = 1'b1;
        bus.gate_up   = 1'b1;
        bus.red_light = flash_on;
      end
      FAULT: begin
        bus.gate      = 1'b1;
        bus.gate_dn   = 1'b1;
        bus.red_light = 1'b1;
        bus.bell      = 1'b1;
        bus.fault     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crossing_sequencer.sv
// Bench for crossing_sequencer: event-level reference model plus directed train scenarios.
module tb_crossing_sequencer;

  localparam int unsigned WARN_CYCLES  = 16;
  localparam int unsigned MOVE_TIMEOUT = 32;
  localparam int unsigned CLEAR_HOLD   = 8;
  localparam int unsigned FLASH_HALF   = 4;
  localparam int unsigned OCC_TIMEOUT  = 1024;

  logic clk = 1'b0;
  logic reset;
  crossing_sequencer_if bus ();

  crossing_sequencer #(
    .WARN_CYCLES(WARN_CYCLES), .MOVE_TIMEOUT(MOVE_TIMEOUT), .CLEAR_HOLD(CLEAR_HOLD),
    .FLASH_HALF(FLASH_HALF), .OCC_TIMEOUT(OCC_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;
  int base     = 0;

  // ---------------- reference model ----------------
  typedef enum int {M_OPEN, M_WARN, M_LOWER, M_CLOSED, M_RAISE, M_FAULT} phase_t;
  phase_t ph;
  int unsigned el, clear_run, since_open;
  logic [3:0] hist [4];        // rails sampled at the previous four edges, newest first
  int unsigned dir [2];        // 0 empty, 1 entered from west, 2 entered from east
  bit leaving [2];
  int unsigned age [2];
  logic [5:0] exp_out;         // gate, gate_dn, gate_up, red_light, bell, fault

  function automatic logic [5:0] outputs_for(input phase_t p, input int unsigned since);
    logic red;
    red = ((since / FLASH_HALF) % 2) == 0;
    case (p)
      M_WARN:   return {1'b0, 1'b0, 1'b0, red, 1'b1, 1'b0};
      M_LOWER:  return {1'b1, 1'b1, 1'b0, red, 1'b1, 1'b0};
      M_CLOSED: return {1'b1, 1'b0, 1'b0, red, 1'b0, 1'b0};
      M_RAISE:  return {1'b1, 1'b0, 1'b1, red, 1'b0, 1'b0};
      M_FAULT:  return 6'b110111;
      default:  return 6'b000000;
    endcase
  endfunction

  task automatic model_reset();
    ph = M_OPEN; el = 0; clear_run = 0; since_open = 0;
    for (int k = 0; k < 4; k++) hist[k] = '0;
    for (int t = 0; t < 2; t++) begin dir[t] = 0; leaving[t] = 0; age[t] = 0; end
  endtask

  task automatic model_step();
    logic [3:0] now;
    bit occ_any, tf_any, rw, re, fw, fe;
    phase_t nxt;
    int unsigned el_n;
    now = {bus.rail_D, bus.rail_C, bus.rail_B, bus.rail_A};
    occ_any = (dir[0] != 0) || (dir[1] != 0);
    tf_any  = (age[0] == OCC_TIMEOUT) || (age[1] == OCC_TIMEOUT);
    since_open = (ph == M_OPEN) ? 0 : since_open + 1;
    el_n = el + 1;
    nxt = ph;
    if (tf_any) nxt = M_FAULT;
    else if (ph != M_OPEN && bus.gate_down_ack && bus.gate_up_ack) nxt = M_FAULT;
    else case (ph)
      M_OPEN:   if (bus.enable && occ_any) nxt = M_WARN;
      M_WARN:   if (el_n >= WARN_CYCLES) nxt = M_LOWER;
      M_LOWER:  if (bus.gate_down_ack) nxt = M_CLOSED;
                else if (el_n >= MOVE_TIMEOUT) nxt = M_FAULT;
      M_CLOSED: begin
        clear_run = occ_any ? 0 : clear_run + 1;
        if (clear_run >= CLEAR_HOLD) nxt = M_RAISE;
      end
      M_RAISE:  if (occ_any) nxt = M_LOWER;
                else if (bus.gate_up_ack) nxt = M_OPEN;
                else if (el_n >= MOVE_TIMEOUT) nxt = M_FAULT;
      default: ;
    endcase
    if (nxt != ph) begin el = 0; clear_run = 0; end
    else el = el_n;
    ph = nxt;
    // sensor level seen three edges ago versus four edges ago
    for (int t = 0; t < 2; t++) begin
      rw = hist[2][2*t]   & ~hist[3][2*t];
      fw = ~hist[2][2*t]  & hist[3][2*t];
      re = hist[2][2*t+1] & ~hist[3][2*t+1];
      fe = ~hist[2][2*t+1] & hist[3][2*t+1];
      if (dir[t] == 0) age[t] = 0;
      else if (age[t] < OCC_TIMEOUT) age[t] = age[t] + 1;
      if (dir[t] == 0) begin
        if (rw) dir[t] = 1;
        else if (re) dir[t] = 2;
      end else if (!leaving[t]) begin
        if ((dir[t] == 1 && re) || (dir[t] == 2 && rw)) leaving[t] = 1;
      end else if ((dir[t] == 1 && fe) || (dir[t] == 2 && fw)) begin
        dir[t] = 0;
        leaving[t] = 0;
      end
    end
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = now;
  endtask

  initial begin
    model_reset();
    exp_out = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
      exp_out = outputs_for(ph, since_open);
    end
  end

  initial forever begin
    @(posedge clk);
    edge_no++;
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (edge_no > 1) begin
      n_checks++;
      if ({bus.gate, bus.gate_dn, bus.gate_up, bus.red_light, bus.bell, bus.fault} !== exp_out) begin
        n_fail++;
        $display("FAIL outputs edge %0d: got %b expected %b (gate,gate_dn,gate_up,red_light,bell,fault)",
                 edge_no, {bus.gate, bus.gate_dn, bus.gate_up, bus.red_light, bus.bell, bus.fault},
                 exp_out);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic start();
    @(negedge clk);
    base = edge_no + 1;
  endtask

  task automatic after(input int k);
    while (edge_no < base + k) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.rail_A = 0; bus.rail_B = 0; bus.rail_C = 0; bus.rail_D = 0;
    bus.gate_down_ack = 0; bus.gate_up_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    clear_inputs();
    @(negedge clk);
    chk("reset clears fault", bus.fault, 1'b0);
    chk("reset clears gate", bus.gate, 1'b0);
    @(negedge clk);
    reset = 1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 0;
    bus.enable = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset = 1;
    chk("reset gate", bus.gate, 1'b0);
    chk("reset red_light", bus.red_light, 1'b0);
    chk("reset bell", bus.bell, 1'b0);
    chk("reset fault", bus.fault, 1'b0);
    repeat (3) @(negedge clk);

    // single train, west to east on track 0
    start(); bus.rail_A = 1;
    after(1);  bus.rail_A = 0;
    after(3);  chk("s1 bell before warn", bus.bell, 1'b0);
    after(4);  chk("s1 bell in warn", bus.bell, 1'b1); chk("s1 red first half", bus.red_light, 1'b1);
    after(8);  chk("s1 red second half", bus.red_light, 1'b0);
    after(19); chk("s1 gate_dn before lower", bus.gate_dn, 1'b0);
    after(20); chk("s1 gate_dn lower", bus.gate_dn, 1'b1); chk("s1 gate lower", bus.gate, 1'b1);
    after(24); bus.gate_down_ack = 1;
    after(25); bus.gate_down_ack = 0;
    chk("s1 closed gate_dn", bus.gate_dn, 1'b0); chk("s1 closed bell", bus.bell, 1'b0);
    after(27); bus.rail_B = 1;
    after(29); bus.rail_B = 0;
    after(40); chk("s1 gate_up early", bus.gate_up, 1'b0);
    after(41); chk("s1 gate_up hold done", bus.gate_up, 1'b1);
    after(43); bus.gate_up_ack = 1;
    after(44); bus.gate_up_ack = 0;
    chk("s1 open gate", bus.gate, 1'b0); chk("s1 open red", bus.red_light, 1'b0);
    after(48);

    // overlapping trains: track 0 east-to-west, track 1 west-to-east
    start(); bus.rail_B = 1;
    after(1);  bus.rail_B = 0; bus.rail_C = 1;
    after(3);  bus.rail_C = 0;
    after(20); chk("s2 gate_dn", bus.gate_dn, 1'b1);
    after(24); bus.gate_down_ack = 1;
    after(25); bus.gate_down_ack = 0;
    after(27); bus.rail_A = 1;
    after(29); bus.rail_A = 0;
    after(39); bus.rail_D = 1;
    after(43); bus.rail_D = 0;
    after(45); chk("s2 track1 still holds gate_up", bus.gate_up, 1'b0); chk("s2 gate held", bus.gate, 1'b1);
    after(54); chk("s2 gate_up early", bus.gate_up, 1'b0);
    after(55); chk("s2 gate_up after both clear", bus.gate_up, 1'b1);
    after(57); bus.gate_up_ack = 1;
    after(58); bus.gate_up_ack = 0; chk("s2 open", bus.gate, 1'b0);
    after(62);

    // new occupancy during raise goes straight back to lowering
    start(); bus.rail_C = 1;
    after(1);  bus.rail_C = 0;
    after(24); bus.gate_down_ack = 1;
    after(25); bus.gate_down_ack = 0; bus.rail_D = 1;
    after(27); bus.rail_D = 0;
    after(38); chk("s3 gate_up early", bus.gate_up, 1'b0);
    after(39); chk("s3 raise", bus.gate_up, 1'b1); bus.rail_C = 1;
    after(41); bus.rail_C = 0;
    after(43); chk("s3 still raising", bus.gate_up, 1'b1);
    after(44); chk("s3 relower gate_dn", bus.gate_dn, 1'b1); chk("s3 relower gate_up", bus.gate_up, 1'b0);
    chk("s3 relower gate", bus.gate, 1'b1);
    after(45); bus.gate_down_ack = 1;
    after(46); bus.gate_down_ack = 0;
    after(47); bus.rail_D = 1;
    after(49); bus.rail_D = 0;
    after(61); chk("s3 second raise", bus.gate_up, 1'b1);
    after(62); bus.gate_up_ack = 1;
    after(63); bus.gate_up_ack = 0; chk("s3 open", bus.gate, 1'b0);
    after(67);

    // gate never reports down
    start(); bus.rail_A = 1;
    after(1);  bus.rail_A = 0;
    after(51); chk("s4 fault early", bus.fault, 1'b0);
    after(52); chk("s4 fault", bus.fault, 1'b1); chk("s4 fault gate_dn", bus.gate_dn, 1'b1);
    chk("s4 fault red", bus.red_light, 1'b1);
    after(57); chk("s4 red steady", bus.red_light, 1'b1);
    after(70); chk("s4 fault sticky", bus.fault, 1'b1);
    do_reset();

    // enable low blocks a new sequence
    bus.enable = 0;
    start(); bus.rail_A = 1;
    after(1);  bus.rail_A = 0;
    after(3);  bus.rail_B = 1;
    after(5);  bus.rail_B = 0;
    after(6);  chk("s5 disabled bell", bus.bell, 1'b0);
    after(12); chk("s5 disabled gate", bus.gate, 1'b0);
    after(14); bus.enable = 1;

    // enable dropped mid-warn does not stop the sequence
    start(); bus.rail_A = 1;
    after(1);  bus.rail_A = 0;
    after(6);  bus.enable = 0; chk("s5 warn bell", bus.bell, 1'b1);
    after(20); chk("s5 lower despite enable", bus.gate_dn, 1'b1);
    after(24); bus.gate_down_ack = 1;
    after(25); bus.gate_down_ack = 0; chk("s5 closed gate", bus.gate, 1'b1);
    after(27); bus.rail_B = 1;
    after(29); bus.rail_B = 0;
    after(41); chk("s5 raise", bus.gate_up, 1'b1);
    after(43); bus.gate_up_ack = 1;
    after(44); bus.gate_up_ack = 0; chk("s5 open", bus.gate, 1'b0); bus.enable = 1;
    after(48);

    // reset asserted while lowering
    start(); bus.rail_A = 1;
    after(1);  bus.rail_A = 0;
    after(22); chk("s6 lowering", bus.gate_dn, 1'b1);
    #2 reset = 0;
    #1;
    chk("s6 async gate", bus.gate, 1'b0); chk("s6 async gate_dn", bus.gate_dn, 1'b0);
    chk("s6 async bell", bus.bell, 1'b0); chk("s6 async red", bus.red_light, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    repeat (10) @(negedge clk);
    chk("s6 stays open", bus.gate, 1'b0); chk("s6 no bell", bus.bell, 1'b0);

    // both limit switches at once
    start(); bus.rail_A = 1;
    after(1);  bus.rail_A = 0;
    after(6);  chk("s7 no fault yet", bus.fault, 1'b0);
    bus.gate_down_ack = 1; bus.gate_up_ack = 1;
    after(7);  chk("s7 both acks fault", bus.fault, 1'b1); chk("s7 gate_up off", bus.gate_up, 1'b0);
    bus.gate_down_ack = 0; bus.gate_up_ack = 0;
    after(9);
    do_reset();

    // train stuck on track 1 while open and disabled
    bus.enable = 0;
    start(); bus.rail_C = 1;
    after(1);    bus.rail_C = 0;
    after(1027); chk("s8 fault early", bus.fault, 1'b0); chk("s8 gate open", bus.gate, 1'b0);
    after(1028); chk("s8 occupancy fault", bus.fault, 1'b1); chk("s8 gate closed", bus.gate, 1'b1);
    bus.enable = 1;
    after(1030);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crossing_sequencer.md
Name: crossing_sequencer

Overview:
- Clocked controller that sequences one level-crossing gate shared by two tracks.
- Track 0 uses sensors rail_A (west) and rail_B (east); track 1 uses rail_C (west) and rail_D (east).
- Tracks occupancy per track, runs warn, lower, hold, raise and fault sequencing, and drives gate motor commands using gate position feedback.
- Sits between raw trackside sensors and the gate actuator/lamp drivers.

Parameters:
- WARN_CYCLES, 16: clocks of flashing warning before the lower command.
- MOVE_TIMEOUT, 32: maximum clocks for gate travel before fault.
- CLEAR_HOLD, 8: clocks both tracks must stay clear before raising.
- FLASH_HALF, 4: clocks per red_light on/off half-period.
- OCC_TIMEOUT, 1024: maximum clocks a track may stay occupied before fault.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- enable  in  1  1 = new occupancy may start a closing sequence.
- rail_A, rail_B, rail_C, rail_D  in  1 each  asynchronous sensors; 1 = wheel present.
- gate_down_ack  in  1  limit switch, gate fully down.
- gate_up_ack  in  1  limit switch, gate fully up.
- gate  out  1  1 = crossing closed (gate commanded or held down).
- gate_dn  out  1  lower motor command.
- gate_up  out  1  raise motor command.
- red_light  out  1  flashing warning lamp.
- bell  out  1  audible warning.
- fault  out  1  sticky fault indication.

Behaviour:
- Reset (reset=0): all outputs 0, both trackers T_IDLE, master OPEN, timers 0, flash phase on.
- Sensor inputs: 2-flop synchroniser per rail, then rise/fall detect against a third register.
  - A sensor level change sampled at edge 0 produces a tracker update at edge 3.
  - Master reacts at edge 4.
- Tracker FSM, one per track:
  - T_IDLE: west rise -> T_IN_WE; east rise -> T_IN_EW; both rise same cycle -> T_IN_WE.
  - T_IN_WE: east rise -> T_EXIT. T_IN_EW: west rise -> T_EXIT. Entry-side re-rises are ignored.
  - T_EXIT: exit-side sensor fall -> T_IDLE.
  - occupied = (state != T_IDLE).
  - Occupancy counter clears on entering T_IDLE; reaching OCC_TIMEOUT asserts track_fault.
- Master FSM:
  - OPEN: all motor and lamp outputs 0. If enable=1 and any occupied -> WARN, timer=WARN_CYCLES.
  - WARN: red_light flashing, bell=1. Timer decrements; at 0 -> LOWER, timer=MOVE_TIMEOUT.
  - LOWER: gate=1, gate_dn=1, red_light flashing, bell=1. gate_down_ack -> CLOSED; timer 0 without ack -> FAULT.
  - CLOSED: gate=1, gate_dn=0, red_light flashing, bell=0. With no track occupied, count CLEAR_HOLD; any occupied reloads the count; expiry -> RAISE, timer=MOVE_TIMEOUT.
  - RAISE: gate=1, gate_up=1, red_light flashing.
    - gate_up_ack -> OPEN.
    - Any occupancy -> LOWER immediately, with no re-warn and timer reloaded.
    - Timer 0 -> FAULT.
  - FAULT: gate=1, gate_dn=1, gate_up=0, red_light steady 1, bell=1, fault=1. Exit only via reset.
- Flash: counter runs only outside OPEN. red_light is on for the first FLASH_HALF clocks after leaving OPEN, then toggles every FLASH_HALF clocks.
- enable=0 only blocks the OPEN->WARN transition. Sequences already in progress complete normally.
- Boundary conditions:
  - gate_down_ack and gate_up_ack both 1 -> FAULT from any non-OPEN state.
  - track_fault -> FAULT from any state, including OPEN.
  - Both tracks occupied: the gate stays closed until both are clear for CLEAR_HOLD.
- Timers are $clog2(max param + 1) bits wide; no wrap is allowed.

Decomposition:
- crossing_pkg: master state enum (OPEN, WARN, LOWER, CLOSED, RAISE, FAULT), tracker state enum (T_IDLE, T_IN_WE, T_IN_EW, T_EXIT), and default timing constants.
- Sub-module track_tracker: synchroniser, edge detect, tracker FSM and occupancy timeout. Instantiated twice (A/B and C/D).

Test Plan:
- Reset, then pulse rail_A at edge 0 -> WARN at edge 4; gate_dn=1 at edge 20. Ack at edge 25 -> CLOSED. rail_B rise then fall -> gate_up asserts CLEAR_HOLD=8 clocks after tracker clear; gate_up_ack -> OPEN, all outputs 0.
- Train on track 0 east-to-west (rail_B then rail_A) overlapping a train on track 1 (rail_C, rail_D) -> gate stays closed until the later track clears, plus 8 clocks.
- rail_C rises during RAISE -> next state LOWER (gate_dn=1, gate_up=0) with no WARN.
- Withhold gate_down_ack -> FAULT 32 clocks after LOWER entry. fault=1, red_light steady 1. Only reset=0 clears it.
- enable=0 with rail_A pulse -> stays OPEN, outputs 0. enable=0 applied mid-WARN -> sequence continues to CLOSED.
- Assert reset mid-LOWER -> all outputs 0 immediately, without waiting for a clock edge; after release with sensors low -> stays OPEN.
